// File: rtl/round_ctrl_bestof_pkg.sv
// Shared codes for the best-of rock-paper-scissors match controller:
// gesture, phase and winner encodings plus the round judging function.
package rps_pkg;

  localparam logic [1:0] GEST_NONE  = 2'b00;
  localparam logic [1:0] GEST_ROCK  = 2'b01;
  localparam logic [1:0] GEST_SCIS  = 2'b10;
  localparam logic [1:0] GEST_PAPER = 2'b11;

  typedef enum logic [2:0] {
    PH_IDLE   = 3'd0,
    PH_ARMED  = 3'd1,
    PH_COUNT  = 3'd2,
    PH_REVEAL = 3'd3,
    PH_HOLD   = 3'd4,
    PH_DONE   = 3'd5
  } phase_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_A    = 2'b01;
  localparam logic [1:0] WIN_B    = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  // A missing gesture forfeits to the other player; two missing gestures draw.
  function automatic logic [1:0] rps_judge(input logic [1:0] ga, input logic [1:0] gb);
    logic a_beats_b;
    a_beats_b = (ga == GEST_ROCK  && gb == GEST_SCIS)  ||
                (ga == GEST_SCIS  && gb == GEST_PAPER) ||
                (ga == GEST_PAPER && gb == GEST_ROCK);
    if (ga == gb)             return WIN_DRAW;
    else if (ga == GEST_NONE) return WIN_B;
    else if (gb == GEST_NONE) return WIN_A;
    else if (a_beats_b)       return WIN_A;
    else                      return WIN_B;
  endfunction

endpackage

// File: rtl/round_ctrl_bestof_if.sv
// Key/gesture inputs and score/phase outputs of the match controller.
interface round_ctrl_bestof_if #(parameter int SCORE_W = 4);
  logic               ready;
  logic               start;
  logic [1:0]         gest_a;
  logic [1:0]         gest_b;
  logic [SCORE_W-1:0] A;
  logic [SCORE_W-1:0] B;
  logic [2:0]         phase;
  logic [3:0]         count;
  logic [1:0]         round_winner;
  logic               match_over;

  modport master (output ready, start, gest_a, gest_b,
                  input  A, B, phase, count, round_winner, match_over);
  modport slave  (input  ready, start, gest_a, gest_b,
                  output A, B, phase, count, round_winner, match_over);
endinterface

// File: rtl/round_ctrl_bestof_tick.sv
// One-second tick generator: counts 0..CLK_HZ-1 and pulses tick_o on the last count.
module sec_tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);
  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CW'(CLK_HZ - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/round_ctrl_bestof.sv
// Best-of rock-paper-scissors match controller: arm, countdown, reveal, hold, until WIN_TARGET.
// Optional build macro DRAW_REPLAY_EN: a drawn round restarts the countdown straight from HOLD.
module round_ctrl_bestof
  import rps_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int COUNT_SEC       = 3,
  parameter int RESULT_HOLD_SEC = 2,
  parameter int WIN_TARGET      = 3,
  parameter int SCORE_W         = 4
) (
  input  logic               clk,
  input  logic               rst,
  round_ctrl_bestof_if.slave bus
);
  localparam int HW = $clog2(RESULT_HOLD_SEC + 1);
`ifdef DRAW_REPLAY_EN
  localparam bit DRAW_REPLAY = 1'b1;
`else
  localparam bit DRAW_REPLAY = 1'b0;
`endif

  if (WIN_TARGET > (2**SCORE_W) - 1) begin : g_bad_score_w
    $error("WIN_TARGET does not fit in SCORE_W bits");
  end

  phase_e             state_q, state_d;
  logic [3:0]         count_q, count_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [SCORE_W-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]         win_q, win_d;
  logic               match_over_q;
  logic               tick, clr;
  logic [1:0]         judged;

  sec_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clr),
    .tick_o (tick)
  );

  assign judged = rps_judge(bus.gest_a, bus.gest_b);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hold_d  = hold_q;
    a_d     = a_q;
    b_d     = b_q;
    win_d   = win_q;
    clr     = 1'b0;
    case (state_q)
      PH_IDLE: if (bus.ready) state_d = PH_ARMED;
      PH_ARMED: begin
        if (bus.start) begin
          state_d = PH_COUNT;
          count_d = 4'(COUNT_SEC);
          win_d   = WIN_NONE;
          clr     = 1'b1;
        end
      end
      PH_COUNT: begin
        if (tick) begin
          count_d = count_q - 4'd1;
          if (count_q == 4'd1) state_d = PH_REVEAL;
        end
      end
      PH_REVEAL: begin
        win_d   = judged;
        state_d = PH_HOLD;
        hold_d  = HW'(RESULT_HOLD_SEC);
        clr     = 1'b1;
        if (judged == WIN_A && a_q < SCORE_W'(WIN_TARGET)) a_d = a_q + SCORE_W'(1);
        if (judged == WIN_B && b_q < SCORE_W'(WIN_TARGET)) b_d = b_q + SCORE_W'(1);
      end
      PH_HOLD: begin
        if (tick) begin
          hold_d = hold_q - HW'(1);
          if (hold_q == HW'(1)) begin
            if (a_q == SCORE_W'(WIN_TARGET) || b_q == SCORE_W'(WIN_TARGET)) begin
              state_d = PH_DONE;
            end else if (DRAW_REPLAY && win_q == WIN_DRAW) begin
              state_d = PH_COUNT;
              count_d = 4'(COUNT_SEC);
              win_d   = WIN_NONE;
              clr     = 1'b1;
            end else begin
              state_d = PH_ARMED;
            end
          end
        end
      end
      PH_DONE: begin
        if (bus.ready) begin
          state_d = PH_ARMED;
          a_d     = '0;
          b_d     = '0;
          win_d   = WIN_NONE;
        end
      end
      default: state_d = PH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= PH_IDLE;
      count_q      <= '0;
      hold_q       <= '0;
      a_q          <= '0;
      b_q          <= '0;
      win_q        <= WIN_NONE;
      match_over_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      hold_q       <= hold_d;
      a_q          <= a_d;
      b_q          <= b_d;
      win_q        <= win_d;
      match_over_q <= (state_d == PH_DONE);
    end
  end

  assign bus.A            = a_q;
  assign bus.B            = b_q;
  assign bus.phase        = state_q;
  assign bus.count        = count_q;
  assign bus.round_winner = win_q;
  assign bus.match_over   = match_over_q;
endmodule

// File: tb/tb_round_ctrl_bestof.sv
// Randomized match bench: a transaction-level score model predicts every round outcome.
module tb_round_ctrl_bestof;
  import rps_pkg::*;

  localparam int CLK_HZ   = 10;
  localparam int COUNT_S  = 3;
  localparam int HOLD_S   = 1;
  localparam int WIN_T    = 2;
  localparam int SW       = 4;
`ifdef DRAW_REPLAY_EN
  localparam bit REPLAY = 1'b1;
`else
  localparam bit REPLAY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  round_ctrl_bestof_if #(.SCORE_W(SW)) bus ();

  round_ctrl_bestof #(
    .CLK_HZ(CLK_HZ), .COUNT_SEC(COUNT_S), .RESULT_HOLD_SEC(HOLD_S),
    .WIN_TARGET(WIN_T), .SCORE_W(SW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int m_a   = 0;
  int m_b   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference rule: each gesture beats exactly one other; absence forfeits.
  function automatic int ref_winner(input int ga, input int gb);
    int victim;
    case (ga)
      1: victim = 2;
      2: victim = 3;
      default: victim = 1;
    endcase
    if (ga == gb) return 3;
    if (ga == 0)  return 2;
    if (gb == 0)  return 1;
    return (victim == gb) ? 1 : 2;
  endfunction

  // Ignored pulses may be sprinkled in, but never on the final cycle of a wait.
  task automatic wait_cyc(input int n, input bit noise);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.ready = noise && (i < n - 1) && ($urandom_range(0, 3) == 0);
      bus.start = noise && (i < n - 1) && ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic pulse(input bit r, input bit s);
    bus.ready = r;
    bus.start = s;
    @(negedge clk);
    bus.ready = 1'b0;
    bus.start = 1'b0;
  endtask

  // Entered on the negedge right after the countdown has been launched.
  task automatic run_round(input logic [1:0] ga, input logic [1:0] gb,
                           input logic [1:0] ra, input logic [1:0] rb);
    logic [1:0] cur_a, cur_b;
    int w, exp_ph, iter;
    bit again;
    cur_a = ga;
    cur_b = gb;
    iter  = 0;
    do begin
      chk("count_load", bus.count, COUNT_S);
      chk("phase_count", bus.phase, PH_COUNT);
      chk("winner_clr", bus.round_winner, WIN_NONE);
      wait_cyc(9, 1'b1);
      chk("count_pretick", bus.count, 3);
      wait_cyc(1, 1'b0);
      chk("count_2", bus.count, 2);
      wait_cyc(10, 1'b1);
      chk("count_1", bus.count, 1);
      wait_cyc(10, 1'b1);
      chk("count_0", bus.count, 0);
      chk("phase_reveal", bus.phase, PH_REVEAL);
      bus.gest_a = cur_a;
      bus.gest_b = cur_b;
      @(negedge clk);
      bus.gest_a = 2'($urandom);
      bus.gest_b = 2'($urandom);
      w = ref_winner(int'(cur_a), int'(cur_b));
      if (w == 1 && m_a < WIN_T) m_a++;
      if (w == 2 && m_b < WIN_T) m_b++;
      chk("round_winner", bus.round_winner, w);
      chk("score_a", bus.A, m_a);
      chk("score_b", bus.B, m_b);
      chk("phase_hold", bus.phase, PH_HOLD);
      wait_cyc(9, 1'b1);
      chk("hold_kept", bus.phase, PH_HOLD);
      wait_cyc(1, 1'b0);
      again  = REPLAY && (w == 3) && (m_a != WIN_T) && (m_b != WIN_T);
      exp_ph = (m_a == WIN_T || m_b == WIN_T) ? PH_DONE : (again ? PH_COUNT : PH_ARMED);
      chk("phase_after_hold", bus.phase, exp_ph);
      chk("match_over", bus.match_over, (exp_ph == PH_DONE) ? 1 : 0);
      $display("round ga=%0d gb=%0d winner=%0d A=%0d B=%0d phase=%0d",
               cur_a, cur_b, bus.round_winner, bus.A, bus.B, bus.phase);
      cur_a = ra;
      cur_b = rb;
      iter++;
    end while (again && iter < 8);
  endtask

  task automatic start_round(input logic [1:0] ga, input logic [1:0] gb,
                             input logic [1:0] ra, input logic [1:0] rb);
    pulse(1'b0, 1'b1);
    run_round(ga, gb, ra, rb);
  endtask

  task automatic finish_match();
    pulse(1'b0, 1'b1);
    chk("done_start_ign", bus.phase, PH_DONE);
    chk("done_score_held", bus.A + bus.B, m_a + m_b);
    pulse(1'b1, 1'b0);
    m_a = 0;
    m_b = 0;
    chk("clear_phase", bus.phase, PH_ARMED);
    chk("clear_a", bus.A, 0);
    chk("clear_b", bus.B, 0);
    chk("clear_win", bus.round_winner, WIN_NONE);
    chk("clear_over", bus.match_over, 0);
    $display("match cleared phase=%0d", bus.phase);
  endtask

  initial begin
    logic [1:0] ga, gb, ra, rb;
    int guard;
    bus.ready  = 1'b0;
    bus.start  = 1'b0;
    bus.gest_a = GEST_NONE;
    bus.gest_b = GEST_NONE;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wait_cyc(100, 1'b0);
    chk("rst_phase", bus.phase, PH_IDLE);
    chk("rst_a", bus.A, 0);
    chk("rst_b", bus.B, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_over", bus.match_over, 0);
    chk("rst_win", bus.round_winner, WIN_NONE);

    pulse(1'b0, 1'b1);
    chk("idle_start_ign", bus.phase, PH_IDLE);
    pulse(1'b1, 1'b1);
    chk("idle_both_armed", bus.phase, PH_ARMED);
    chk("idle_both_count", bus.count, 0);
    wait_cyc(3, 1'b0);
    chk("armed_stays", bus.phase, PH_ARMED);
    $display("arm ready+start phase=%0d count=%0d", bus.phase, bus.count);

    start_round(GEST_ROCK, GEST_SCIS, GEST_ROCK, GEST_SCIS);
    pulse(1'b1, 1'b0);
    chk("armed_ready_ign", bus.phase, PH_ARMED);
    start_round(GEST_PAPER, GEST_PAPER, GEST_SCIS, GEST_ROCK);
    guard = 0;
    while (m_a < WIN_T && m_b < WIN_T && guard < 6) begin
      start_round(GEST_ROCK, GEST_SCIS, GEST_ROCK, GEST_SCIS);
      guard++;
    end
    chk("match_a_target", bus.A, WIN_T);
    chk("match_done", bus.phase, PH_DONE);
    finish_match();

    start_round(GEST_NONE, GEST_ROCK, GEST_ROCK, GEST_SCIS);

    for (int r = 0; r < 14; r++) begin
      if (m_a == WIN_T || m_b == WIN_T) finish_match();
      wait_cyc($urandom_range(0, 5), 1'b0);
      ga = 2'($urandom_range(0, 3));
      gb = 2'($urandom_range(0, 3));
      ra = 2'($urandom_range(1, 3));
      rb = (ra == GEST_PAPER) ? GEST_ROCK : ra + 2'd1;
      if ($urandom_range(0, 1) == 1) begin
        logic [1:0] t;
        t = ra; ra = rb; rb = t;
      end
      start_round(ga, gb, ra, rb);
    end
    if (m_a == WIN_T || m_b == WIN_T) finish_match();

    pulse(1'b0, 1'b1);
    wait_cyc(5, 1'b0);
    #1 rst = 1'b0;
    #1;
    chk("async_phase", bus.phase, PH_IDLE);
    chk("async_count", bus.count, 0);
    chk("async_a", bus.A, 0);
    chk("async_b", bus.B, 0);
    chk("async_win", bus.round_winner, WIN_NONE);
    chk("async_over", bus.match_over, 0);
    @(negedge clk);
    chk("rst_hold_phase", bus.phase, PH_IDLE);
    rst = 1'b1;
    wait_cyc(3, 1'b0);
    chk("post_rst_idle", bus.phase, PH_IDLE);
    $display("reset mid-count phase=%0d count=%0d", bus.phase, bus.count);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
